// File: rtl/dma_pkg.sv
// Shared types and bit positions for the DMA interrupt controller.
package dma_pkg;

  localparam int IRQ_DONE_BIT = 0;
  localparam int IRQ_ERR_BIT  = 1;

  typedef enum logic [1:0] {
    IRQ_IDLE     = 2'd0,
    IRQ_COALESCE = 2'd1,
    IRQ_FIRE     = 2'd2
  } irq_state_e;

endpackage

// File: rtl/dma_irq_coalescer.sv
// Done-event coalescing: pending counter, timeout timer and the IDLE/COALESCE/FIRE FSM.
module dma_irq_coalescer
  import dma_pkg::*;
#(
  parameter int CNT_WIDTH = 8,
  parameter int TMR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 done_evt,
  input  logic                 clr_done,
  input  logic [CNT_WIDTH-1:0] cfg_coal_thresh,
  input  logic [TMR_WIDTH-1:0] cfg_coal_timeout,
  output logic [CNT_WIDTH-1:0] pend_cnt,
  output logic                 fired
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TMR_WIDTH-1:0] TMR_ONE = {{(TMR_WIDTH-1){1'b0}}, 1'b1};

  irq_state_e           state_reg, state_next, state_cur;
  logic [CNT_WIDTH-1:0] pend_cnt_reg, pend_cnt_next;
  logic [CNT_WIDTH-1:0] cnt_base, thresh_eff;
  logic [TMR_WIDTH-1:0] timer_reg, timer_next;
  logic                 timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IRQ_IDLE;
      pend_cnt_reg <= '0;
      timer_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      pend_cnt_reg <= pend_cnt_next;
      timer_reg    <= timer_next;
    end
  end

  always_comb begin
    // A clear lands first, so a same-cycle done event is evaluated from a fresh IDLE.
    cnt_base      = clr_done ? '0 : pend_cnt_reg;
    state_cur     = clr_done ? IRQ_IDLE : state_reg;
    pend_cnt_next = cnt_base;
    if (done_evt && (cnt_base != CNT_MAX)) begin
      pend_cnt_next = cnt_base + CNT_ONE;
    end
    thresh_eff  = (cfg_coal_thresh == '0) ? CNT_ONE : cfg_coal_thresh;
    timeout_hit = (cfg_coal_timeout != '0) && (timer_reg == (cfg_coal_timeout - TMR_ONE));
    state_next  = state_cur;
    timer_next  = timer_reg;

    case (state_cur)
      IRQ_IDLE: begin
        timer_next = '0;
        if (done_evt) begin
          if (pend_cnt_next >= thresh_eff) begin
            state_next = IRQ_FIRE;
          end else begin
            state_next = IRQ_COALESCE;
          end
        end
      end
      IRQ_COALESCE: begin
        if ((pend_cnt_next >= thresh_eff) || timeout_hit) begin
          state_next = IRQ_FIRE;
        end else begin
          timer_next = timer_reg + TMR_ONE;
        end
      end
      IRQ_FIRE: begin
        state_next = IRQ_FIRE;
      end
      default: begin
        state_next = IRQ_IDLE;
        timer_next = '0;
      end
    endcase
  end

  assign pend_cnt = pend_cnt_reg;
  assign fired    = (state_reg == IRQ_FIRE);

endmodule

// File: rtl/dma_irq_ctrl.sv
// DMA interrupt controller: edge detection, sticky error status, done coalescing and masked irq.
module dma_irq_ctrl
  import dma_pkg::*;
#(
  parameter int CNT_WIDTH = 8,
  parameter int TMR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dma_done_i,
  input  logic                 dma_error_i,
  input  logic [1:0]           cfg_irq_en_i,
  input  logic [CNT_WIDTH-1:0] cfg_coal_thresh_i,
  input  logic [TMR_WIDTH-1:0] cfg_coal_timeout_i,
  input  logic                 clr_valid_i,
  input  logic [1:0]           clr_mask_i,
  output logic                 irq_o,
  output logic [1:0]           irq_status_o,
  output logic [CNT_WIDTH-1:0] pend_cnt_o
);

  logic [1:0] src_in, src_prev_reg, src_evt, clr_bits;
  logic       err_status_reg, err_status_next;
  logic       done_fired;

  assign src_in[IRQ_DONE_BIT] = dma_done_i;
  assign src_in[IRQ_ERR_BIT]  = dma_error_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_evt[gi]  = src_in[gi] & ~src_prev_reg[gi];
      assign clr_bits[gi] = clr_valid_i & clr_mask_i[gi];
    end
  endgenerate

  // A same-cycle error event outranks the clear.
  assign err_status_next = src_evt[IRQ_ERR_BIT] | (err_status_reg & ~clr_bits[IRQ_ERR_BIT]);

  always_ff @(posedge clk) begin
    if (rst) begin
      src_prev_reg   <= '0;
      err_status_reg <= 1'b0;
    end else begin
      src_prev_reg   <= src_in;
      err_status_reg <= err_status_next;
    end
  end

  dma_irq_coalescer #(
    .CNT_WIDTH (CNT_WIDTH),
    .TMR_WIDTH (TMR_WIDTH)
  ) u_coalescer (
    .clk              (clk),
    .rst              (rst),
    .done_evt         (src_evt[IRQ_DONE_BIT]),
    .clr_done         (clr_bits[IRQ_DONE_BIT]),
    .cfg_coal_thresh  (cfg_coal_thresh_i),
    .cfg_coal_timeout (cfg_coal_timeout_i),
    .pend_cnt         (pend_cnt_o),
    .fired            (done_fired)
  );

  assign irq_status_o[IRQ_DONE_BIT] = done_fired;
  assign irq_status_o[IRQ_ERR_BIT]  = err_status_reg;
  assign irq_o = |(irq_status_o & cfg_irq_en_i);

endmodule

// File: tb/tb_dma_irq_ctrl.sv
// Self-checking bench for dma_irq_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_dma_irq_ctrl;

  localparam int CMAX = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_done_i;
  logic        dma_error_i;
  logic [1:0]  cfg_irq_en_i;
  logic [7:0]  cfg_coal_thresh_i;
  logic [15:0] cfg_coal_timeout_i;
  logic        clr_valid_i;
  logic [1:0]  clr_mask_i;
  logic        irq_o;
  logic [1:0]  irq_status_o;
  logic [7:0]  pend_cnt_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending count, fired flag, waiting flag with age since first pending done.
  int m_cnt;
  int m_age;
  bit m_fired, m_wait, m_err, m_dprev, m_eprev;

  dma_irq_ctrl #(.CNT_WIDTH(8), .TMR_WIDTH(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .dma_done_i         (dma_done_i),
    .dma_error_i        (dma_error_i),
    .cfg_irq_en_i       (cfg_irq_en_i),
    .cfg_coal_thresh_i  (cfg_coal_thresh_i),
    .cfg_coal_timeout_i (cfg_coal_timeout_i),
    .clr_valid_i        (clr_valid_i),
    .clr_mask_i         (clr_mask_i),
    .irq_o              (irq_o),
    .irq_status_o       (irq_status_o),
    .pend_cnt_o         (pend_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    bit dev, eev;
    int te;
    if (rst) begin
      m_cnt = 0; m_age = 0; m_fired = 0; m_wait = 0; m_err = 0; m_dprev = 0; m_eprev = 0;
      return;
    end
    dev = dma_done_i && !m_dprev;
    eev = dma_error_i && !m_eprev;
    m_dprev = dma_done_i;
    m_eprev = dma_error_i;
    if (clr_valid_i && clr_mask_i[0]) begin
      m_cnt = 0; m_fired = 0; m_wait = 0;
    end
    if (clr_valid_i && clr_mask_i[1]) m_err = 0;
    if (eev) m_err = 1;
    if (dev && m_cnt < CMAX) m_cnt++;
    te = (cfg_coal_thresh_i == 0) ? 1 : int'(cfg_coal_thresh_i);
    if (!m_fired) begin
      if (m_cnt >= te) begin
        m_fired = 1; m_wait = 0;
      end else if (m_wait) begin
        m_age++;
        if (cfg_coal_timeout_i != 0 && m_age == int'(cfg_coal_timeout_i)) begin
          m_fired = 1; m_wait = 0;
        end
      end else if (m_cnt > 0) begin
        m_wait = 1; m_age = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_all();
    clr_valid_i = 1'b1; clr_mask_i = 2'b11;
    tick();
    clr_valid_i = 1'b0; clr_mask_i = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; dma_done_i = 0; dma_error_i = 0; cfg_irq_en_i = 2'b11;
    cfg_coal_thresh_i = 8'd1; cfg_coal_timeout_i = 16'd0; clr_valid_i = 0; clr_mask_i = 2'b00;
    tick(); tick();
    rst = 1'b0;
    checks++; if (pend_cnt_o !== 8'd0) begin failures++; $display("FAIL reset_pend: got %0d expected 0", pend_cnt_o); end
    checks++; if (irq_status_o !== 2'b00) begin failures++; $display("FAIL reset_status: got %b expected 00", irq_status_o); end
    checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
    $display("test_reset done");
  endtask

  task automatic test_immediate();
    cfg_coal_thresh_i = 8'd1; cfg_coal_timeout_i = 16'd0; cfg_irq_en_i = 2'b01;
    for (int i = 0; i < 9; i++) tick();
    dma_done_i = 1'b1;
    tick();
    checks++; if (irq_status_o !== 2'b01) begin failures++; $display("FAIL imm_status: got %b expected 01", irq_status_o); end
    checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL imm_irq: got %b expected 1", irq_o); end
    dma_done_i = 1'b0;
    tick();
    clr_valid_i = 1'b1; clr_mask_i = 2'b01;
    tick();
    clr_valid_i = 1'b0; clr_mask_i = 2'b00;
    checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL imm_clear_irq: got %b expected 0", irq_o); end
    checks++; if (pend_cnt_o !== 8'd0) begin failures++; $display("FAIL imm_clear_pend: got %0d expected 0", pend_cnt_o); end
    $display("test_immediate done");
  endtask

  task automatic test_thresh4();
    bit seen;
    cfg_coal_thresh_i = 8'd4; cfg_coal_timeout_i = 16'd0; cfg_irq_en_i = 2'b01;
    for (int p = 0; p < 3; p++) begin
      dma_done_i = 1'b1; tick(); dma_done_i = 1'b0; tick();
    end
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (irq_o !== 1'b0) seen = 1;
    end
    checks++; if (seen) begin failures++; $display("FAIL thr4_no_irq: got irq seen=1 expected 0"); end
    checks++; if (pend_cnt_o !== 8'd3) begin failures++; $display("FAIL thr4_pend3: got %0d expected 3", pend_cnt_o); end
    dma_done_i = 1'b1; tick();
    checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL thr4_irq: got %b expected 1", irq_o); end
    checks++; if (pend_cnt_o !== 8'd4) begin failures++; $display("FAIL thr4_pend4: got %0d expected 4", pend_cnt_o); end
    dma_done_i = 1'b0; tick();
    clear_all();
    $display("test_thresh4 done");
  endtask

  task automatic test_timeout();
    int n;
    cfg_coal_thresh_i = 8'd8; cfg_coal_timeout_i = 16'd20; cfg_irq_en_i = 2'b01;
    dma_done_i = 1'b1; tick(); dma_done_i = 1'b0;
    n = 0;
    while (n < 100) begin
      tick(); n++;
      if (irq_o === 1'b1) break;
    end
    checks++; if (n != 20) begin failures++; $display("FAIL tmo_latency: got %0d cycles expected 20", n); end
    checks++; if (pend_cnt_o !== 8'd1) begin failures++; $display("FAIL tmo_pend: got %0d expected 1", pend_cnt_o); end
    clear_all();
    $display("test_timeout done");
  endtask

  task automatic test_clear_collisions();
    cfg_irq_en_i = 2'b11; cfg_coal_thresh_i = 8'd1; cfg_coal_timeout_i = 16'd0;
    dma_error_i = 1'b1; clr_valid_i = 1'b1; clr_mask_i = 2'b10;
    tick();
    clr_valid_i = 1'b0; clr_mask_i = 2'b00; dma_error_i = 1'b0;
    checks++; if (irq_status_o[1] !== 1'b1) begin failures++; $display("FAIL err_vs_clear: got %b expected 1", irq_status_o[1]); end
    clr_mask_i = 2'b11; tick(); clr_mask_i = 2'b00;
    checks++; if (irq_status_o[1] !== 1'b1) begin failures++; $display("FAIL clr_valid_low: got %b expected 1", irq_status_o[1]); end
    dma_done_i = 1'b1; tick(); dma_done_i = 1'b0; tick();
    dma_done_i = 1'b1; clr_valid_i = 1'b1; clr_mask_i = 2'b01;
    tick();
    clr_valid_i = 1'b0; clr_mask_i = 2'b00; dma_done_i = 1'b0;
    checks++; if (irq_status_o[0] !== 1'b1) begin failures++; $display("FAIL done_vs_clear_status: got %b expected 1", irq_status_o[0]); end
    checks++; if (pend_cnt_o !== 8'd1) begin failures++; $display("FAIL done_vs_clear_pend: got %0d expected 1", pend_cnt_o); end
    clear_all();
    checks++; if (irq_status_o !== 2'b00) begin failures++; $display("FAIL clear_both: got %b expected 00", irq_status_o); end
    clear_all();
    checks++; if (irq_status_o !== 2'b00 || pend_cnt_o !== 8'd0) begin failures++; $display("FAIL clear_idempotent: got %b/%0d expected 00/0", irq_status_o, pend_cnt_o); end
    $display("test_clear_collisions done");
  endtask

  task automatic test_saturation();
    cfg_coal_thresh_i = 8'd0; cfg_coal_timeout_i = 16'd0;
    for (int p = 0; p < 300; p++) begin
      dma_done_i = 1'b1; tick(); dma_done_i = 1'b0; tick();
    end
    checks++; if (pend_cnt_o !== 8'd255) begin failures++; $display("FAIL sat_pend: got %0d expected 255", pend_cnt_o); end
    checks++; if (irq_status_o[0] !== 1'b1) begin failures++; $display("FAIL sat_status: got %b expected 1", irq_status_o[0]); end
    clear_all();
    $display("test_saturation done");
  endtask

  task automatic test_masking();
    cfg_irq_en_i = 2'b00;
    dma_error_i = 1'b1; tick(); dma_error_i = 1'b0; tick();
    checks++; if (irq_status_o !== 2'b10) begin failures++; $display("FAIL mask_status: got %b expected 10", irq_status_o); end
    checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL mask_irq_off: got %b expected 0", irq_o); end
    cfg_irq_en_i = 2'b10;
    #1;
    checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL mask_irq_live: got %b expected 1", irq_o); end
    clear_all();
    $display("test_masking done");
  endtask

  task automatic test_reset_mid();
    cfg_irq_en_i = 2'b11; cfg_coal_thresh_i = 8'd8; cfg_coal_timeout_i = 16'd0;
    dma_error_i = 1'b1; dma_done_i = 1'b1; tick(); dma_error_i = 1'b0; dma_done_i = 1'b0; tick();
    checks++; if (pend_cnt_o !== 8'd1 || irq_status_o !== 2'b10) begin failures++; $display("FAIL mid_pre: got %0d/%b expected 1/10", pend_cnt_o, irq_status_o); end
    dma_done_i = 1'b1;
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (pend_cnt_o !== 8'd0 || irq_status_o !== 2'b00 || irq_o !== 1'b0) begin
      failures++; $display("FAIL mid_reset: got %0d/%b/%b expected 0/00/0", pend_cnt_o, irq_status_o, irq_o);
    end
    tick();
    checks++; if (pend_cnt_o !== 8'd1) begin failures++; $display("FAIL post_reset_evt: got %0d expected 1", pend_cnt_o); end
    dma_done_i = 1'b0; tick();
    clear_all();
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [1:0] exp_status;
    logic       exp_irq;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        cfg_coal_thresh_i  = 8'($urandom_range(0, 5));
        cfg_coal_timeout_i = 16'($urandom_range(0, 25));
        cfg_irq_en_i       = 2'($urandom_range(0, 3));
      end
      dma_done_i  = ($urandom_range(0, 99) < 35);
      dma_error_i = ($urandom_range(0, 99) < 10);
      clr_valid_i = ($urandom_range(0, 99) < 8);
      clr_mask_i  = 2'($urandom_range(0, 3));
      rst         = ($urandom_range(0, 999) < 5);
      tick();
      exp_status = {m_err, m_fired};
      exp_irq    = |(exp_status & cfg_irq_en_i);
      checks++; if (pend_cnt_o !== 8'(m_cnt)) begin failures++; $display("FAIL rnd_pend c=%0d: got %0d expected %0d", c, pend_cnt_o, m_cnt); end
      checks++; if (irq_status_o !== exp_status) begin failures++; $display("FAIL rnd_status c=%0d: got %b expected %b", c, irq_status_o, exp_status); end
      checks++; if (irq_o !== exp_irq) begin failures++; $display("FAIL rnd_irq c=%0d: got %b expected %b", c, irq_o, exp_irq); end
    end
    rst = 1'b0; dma_done_i = 1'b0; dma_error_i = 1'b0; clr_valid_i = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_thresh4();
    test_timeout();
    test_clear_collisions();
    test_saturation();
    test_masking();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_irq_ctrl.md
DMA_IRQ_CTRL -- requirements
Module: dma_irq_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 8, width of the pending-completion counter and of the coalescing threshold.
REQ-002 Parameter TMR_WIDTH, default 16, width of the coalescing timeout timer.
REQ-003 clk  input  1  sole clock; all flops update on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 dma_done_i  input  1  DMA done level from dma_axi_wrapper dma_done_o.
REQ-006 dma_error_i  input  1  DMA error level from dma_axi_wrapper dma_error_o.
REQ-007 cfg_irq_en_i  input  2  interrupt enable; bit0 done, bit1 error.
REQ-008 cfg_coal_thresh_i  input  CNT_WIDTH  done events per interrupt; 0 and 1 both mean immediate.
REQ-009 cfg_coal_timeout_i  input  TMR_WIDTH  cycles from first pending done to forced interrupt; 0 disables the timer.
REQ-010 clr_valid_i  input  1  write-1-to-clear strobe, single cycle, no handshake.
REQ-011 clr_mask_i  input  2  bits cleared when clr_valid_i=1; bit0 done, bit1 error.
REQ-012 irq_o  output  1  level interrupt = |(irq_status_o & cfg_irq_en_i).
REQ-013 irq_status_o  output  2  sticky status; bit0 done, bit1 error.
REQ-014 pend_cnt_o  output  CNT_WIDTH  done events accumulated since last done clear.

Function
REQ-015 Event detection shall register each input (prev flop); event = input & ~prev, evaluated every cycle.
REQ-016 Status and counter updates shall occur at the same edge the event is sampled; irq_o (combinational from flops and cfg_irq_en_i) is therefore high one cycle after the input rises.
REQ-017 Error event shall set irq_status_o[1] immediately, with no coalescing.
REQ-018 Done event shall increment pend_cnt, saturating at 2^CNT_WIDTH-1 without wrap.
REQ-019 FSM states: IDLE (pend_cnt=0), COALESCE (pend_cnt>0, timer running), FIRE (status[0]=1).
REQ-020 IDLE->COALESCE on done event when the new pend_cnt < threshold; IDLE->FIRE directly when the new pend_cnt >= max(threshold,1).
REQ-021 COALESCE->FIRE when pend_cnt reaches threshold, or when timer == cfg_coal_timeout_i-1 with timeout != 0.
REQ-022 The timer shall clear on entry to COALESCE and increment each COALESCE cycle; later done events shall not restart it.
REQ-023 In FIRE, done events shall still increment pend_cnt (saturating); the state holds until cleared.
REQ-024 A clear with clr_mask_i[0]=1 shall zero pend_cnt and status[0] and go to IDLE; a simultaneous done event shall win, giving pend_cnt=1 and re-evaluating REQ-020.
REQ-025 A clear with clr_mask_i[1]=1 shall clear status[1]; a simultaneous error event shall leave it set.
REQ-026 Disabled sources shall still set status; only irq_o is masked. Enabling later shall raise irq_o in the same cycle.
REQ-027 cfg_* inputs shall be used live each cycle. Lowering the threshold to <= pend_cnt in COALESCE shall go to FIRE on the next edge.
REQ-028 Clear of an already-clear bit shall have no effect; clr_valid_i=0 shall ignore clr_mask_i.

Reset
REQ-029 On rst=1 at a clock edge: state IDLE, pend_cnt 0, timer 0, irq_status_o 2'b00, irq_o 0, prev flops 0.
REQ-030 Mid-operation reset shall discard pending counts and status. An input that is high on the first post-reset cycle counts as an event.

Structure
REQ-031 Package dma_pkg shall hold the irq FSM state enum and the localparams IRQ_DONE_BIT=0 and IRQ_ERR_BIT=1.
REQ-032 Sub-module dma_irq_coalescer shall contain pend_cnt, the timer and the FSM; the top level holds edge detection, status bit1 and the irq_o logic.

Verification
REQ-033 thresh=1, en=2'b01: done rises at cycle 10 -> irq_status_o=01 and irq_o=1 from cycle 11; clear mask 01 -> irq_o=0 next cycle.
REQ-034 thresh=4, timeout=0: four done pulses -> irq_o rises only after the 4th, with pend_cnt_o=4; 3 pulses -> no irq for 1000 cycles.
REQ-035 thresh=8, timeout=20: one done pulse -> irq_o rises exactly 20 cycles after entering COALESCE, with pend_cnt_o=1.
REQ-036 Error plus clear mask 10 in the same cycle -> status[1] stays 1; done plus clear mask 01 in FIRE with thresh=1 -> status[0] stays 1 and pend_cnt_o=1.
REQ-037 CNT_WIDTH=8, thresh=0: 300 done pulses without clear -> pend_cnt_o saturates at 255.
REQ-038 en=2'b00, then error pulse -> status=10 and irq_o=0; set en=2'b10 -> irq_o=1 in the same cycle. Reset asserted in COALESCE -> all outputs 0 the next cycle.
